// File: rtl/s_axis_cc_adapt_wide_pkg.sv
// Shared definitions for the s_axis_cc_adapt_wide completer-completion adapter:
// 3DW completion header field offsets, CC descriptor field offsets and the
// length-to-dword-count mapping.
package s_axis_cc_pkg;

    // Incoming 3DW PCIe completion header (first beat, bits [95:0])
    localparam int H_LEN_LSB  = 0;
    localparam int H_ATTR_LSB = 12;
    localparam int H_EP_BIT   = 14;
    localparam int H_TD_BIT   = 15;
    localparam int H_TC_LSB   = 20;
    localparam int H_FT_LSB   = 24;
    localparam int H_BC_LSB   = 32;
    localparam int H_ST_LSB   = 45;
    localparam int H_CID_LSB  = 48;
    localparam int H_LA_LSB   = 64;
    localparam int H_TAG_LSB  = 72;
    localparam int H_RID_LSB  = 80;

    // Outgoing UltraScale CC descriptor
    localparam int D_LA_LSB   = 0;
    localparam int D_BC_LSB   = 16;
    localparam int D_LOCK_BIT = 29;
    localparam int D_DW_LSB   = 32;
    localparam int D_ST_LSB   = 43;
    localparam int D_EP_BIT   = 46;
    localparam int D_RID_LSB  = 48;
    localparam int D_TAG_LSB  = 64;
    localparam int D_CID_LSB  = 72;
    localparam int D_TC_LSB   = 89;
    localparam int D_ATTR_LSB = 92;
    localparam int D_ECRC_BIT = 95;

    localparam int HDR_W     = 96;
    localparam int TUSER_W   = 4;
    localparam int TUSER_A_W = 33;

    localparam logic [5:0] LOCKED_CPL_FMT_TYPE = 6'b001011;

    // A zero length field means the maximum of 1024 dwords
    function automatic logic [10:0] len_to_dwcount(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

endpackage

// File: rtl/s_axis_cc_adapt_wide_if.sv
// Stream bundle for s_axis_cc_adapt_wide: the LitePCIe-side TLP stream and the
// hard-block-side s_axis_cc stream. The adapter uses the slave modport, the
// surrounding logic (or bench) uses the master modport.
interface s_axis_cc_adapt_wide_if
    import s_axis_cc_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH/8
);
    logic [DATA_WIDTH-1:0]    s_axis_cc_tdata;
    logic [KEEP_WIDTH-1:0]    s_axis_cc_tkeep;
    logic                     s_axis_cc_tlast;
    logic                     s_axis_cc_tvalid;
    logic [TUSER_W-1:0]       s_axis_cc_tuser;
    logic                     s_axis_cc_tready;

    logic [DATA_WIDTH-1:0]    s_axis_cc_tdata_a;
    logic [DATA_WIDTH/32-1:0] s_axis_cc_tkeep_a;
    logic                     s_axis_cc_tlast_a;
    logic                     s_axis_cc_tvalid_a;
    logic [TUSER_A_W-1:0]     s_axis_cc_tuser_a;
    logic                     s_axis_cc_tready_a;

    modport slave (
        input  s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast,
               s_axis_cc_tvalid, s_axis_cc_tuser, s_axis_cc_tready_a,
        output s_axis_cc_tready, s_axis_cc_tdata_a, s_axis_cc_tkeep_a,
               s_axis_cc_tlast_a, s_axis_cc_tvalid_a, s_axis_cc_tuser_a
    );

    modport master (
        output s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast,
               s_axis_cc_tvalid, s_axis_cc_tuser, s_axis_cc_tready_a,
        input  s_axis_cc_tready, s_axis_cc_tdata_a, s_axis_cc_tkeep_a,
               s_axis_cc_tlast_a, s_axis_cc_tvalid_a, s_axis_cc_tuser_a
    );
endinterface

// File: rtl/s_axis_cc_adapt_wide_fifo.sv
// cc_sync_fifo: first-word-fall-through synchronous FIFO. DEPTH must be a
// power of two (pointers wrap naturally). Asynchronous active-low reset
// empties the FIFO and clears the storage.
module cc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_valid_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_ready_o,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             rd_ready_i
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push, pop;

    assign wr_ready_o = (count_q < (AW+1)'(DEPTH));
    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = rd_valid_o && rd_ready_i;

    // Storage write and pointer/occupancy bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/s_axis_cc_adapt_wide.sv
// s_axis_cc_adapt_wide: LitePCIe completion stream -> UltraScale s_axis_cc.
// Buffers beats in an FWFT FIFO, rewrites the first beat's 3DW completion
// header into the CC descriptor, derives dword keep, holds discontinue
// sticky to the end of a packet and counts forwarded completions.
// Optional feature: define S_AXIS_CC_PARITY_EN to drive odd byte parity on
// tuser_a[32:1]; otherwise those bits are tied to zero.
module s_axis_cc_adapt_wide
    import s_axis_cc_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  user_clk,
    input  logic                  user_reset_n,
    s_axis_cc_adapt_wide_if.slave cc,
    output logic [15:0]           cpl_count
);
    localparam int DKW    = DATA_WIDTH/32;
    localparam int NBYTES = DATA_WIDTH/8;
    // Only the ECRC-request and discontinue tuser bits matter downstream
    localparam int FW     = 2 + DKW + 1 + DATA_WIDTH;

    logic [DKW-1:0]        dkeep;
    logic [FW-1:0]         wr_data, rd_data;
    logic                  rd_valid;
    logic                  beat_disc, beat_ecrc, beat_last;
    logic [DKW-1:0]        beat_keep;
    logic [DATA_WIDTH-1:0] beat_data, data_a;
    logic [31:0]           parity;
    logic                  disc_out, xfer;
    logic                  first_q, first_d;
    logic                  sticky_q, sticky_d;
    logic [15:0]           cpl_q, cpl_d;

    // Map the completion header onto the CC descriptor
    function automatic logic [HDR_W-1:0] build_desc(input logic [HDR_W-1:0] h,
                                                    input logic ecrc);
        logic [HDR_W-1:0] d;
        d = '0;
        d[D_LA_LSB +: 7]   = h[H_LA_LSB +: 7];
        d[D_BC_LSB +: 13]  = {1'b0, h[H_BC_LSB +: 12]};
        d[D_LOCK_BIT]      = (h[H_FT_LSB +: 6] == LOCKED_CPL_FMT_TYPE);
        d[D_DW_LSB +: 11]  = len_to_dwcount(h[H_LEN_LSB +: 10]);
        d[D_ST_LSB +: 3]   = h[H_ST_LSB +: 3];
        d[D_EP_BIT]        = h[H_EP_BIT];
        d[D_RID_LSB +: 16] = h[H_RID_LSB +: 16];
        d[D_TAG_LSB +: 8]  = h[H_TAG_LSB +: 8];
        d[D_CID_LSB +: 16] = h[H_CID_LSB +: 16];
        d[D_TC_LSB +: 3]   = h[H_TC_LSB +: 3];
        d[D_ATTR_LSB +: 3] = {1'b0, h[H_ATTR_LSB +: 2]};
        d[D_ECRC_BIT]      = h[H_TD_BIT] | ecrc;
        return d;
    endfunction

    // Byte enables collapse to one keep bit per dword
    always_comb begin
        dkeep = '0;
        for (int i = 0; i < DKW; i++) dkeep[i] = |cc.s_axis_cc_tkeep[4*i +: 4];
    end

    assign wr_data = {cc.s_axis_cc_tuser[3], cc.s_axis_cc_tuser[0], dkeep,
                      cc.s_axis_cc_tlast, cc.s_axis_cc_tdata};

    cc_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (user_clk),
        .rst_ni     (user_reset_n),
        .wr_valid_i (cc.s_axis_cc_tvalid),
        .wr_data_i  (wr_data),
        .wr_ready_o (cc.s_axis_cc_tready),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .rd_ready_i (cc.s_axis_cc_tready_a)
    );

    assign {beat_disc, beat_ecrc, beat_keep, beat_last, beat_data} = rd_data;
    assign xfer     = rd_valid && cc.s_axis_cc_tready_a;
    assign disc_out = beat_disc | sticky_q;

    // First beat of a packet carries the rewritten descriptor
    always_comb begin
        data_a = beat_data;
        if (first_q) data_a[HDR_W-1:0] = build_desc(beat_data[HDR_W-1:0], beat_ecrc);
    end

`ifdef S_AXIS_CC_PARITY_EN
    // Odd parity per output byte, taken after the descriptor rewrite
    always_comb begin
        parity = '0;
        for (int k = 0; k < NBYTES; k++) parity[k] = ~^data_a[8*k +: 8];
    end
`else
    assign parity = '0;
`endif

    // Packet-position, sticky-discontinue and completion-count next state
    always_comb begin
        first_d  = first_q;
        sticky_d = sticky_q;
        cpl_d    = cpl_q;
        if (xfer) begin
            first_d  = beat_last;
            sticky_d = beat_last ? 1'b0 : disc_out;
            if (beat_last) cpl_d = cpl_q + 16'd1;
        end
    end

    // Control state registers
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            first_q  <= 1'b1;
            sticky_q <= 1'b0;
            cpl_q    <= '0;
        end else begin
            first_q  <= first_d;
            sticky_q <= sticky_d;
            cpl_q    <= cpl_d;
        end
    end

    // Outputs read as zero whenever nothing is presented
    assign cc.s_axis_cc_tvalid_a = rd_valid;
    assign cc.s_axis_cc_tdata_a  = rd_valid ? data_a : '0;
    assign cc.s_axis_cc_tkeep_a  = rd_valid ? beat_keep : '0;
    assign cc.s_axis_cc_tlast_a  = rd_valid && beat_last;
    assign cc.s_axis_cc_tuser_a  = rd_valid ? {parity, disc_out} : '0;
    assign cpl_count             = cpl_q;
endmodule

// File: doc/s_axis_cc_adapt_wide.md
# s_axis_cc_adapt_wide

Completer-completion (CC) adapter between the LitePCIe TLP stream and the UltraScale PCIe hard block's s_axis_cc interface, parametrised for 128- or 256-bit datapaths. It buffers completions in a small synchronous FIFO and rewrites the first beat's 3DW PCIe completion header into the CC descriptor. It also derives dword-granular tkeep, makes discontinue sticky within a packet, and counts forwarded completions. It sits in the PHY wrapper between the LitePCIe completion arbiter and the hard block.

## Interface
- DATA_WIDTH, 128, datapath width; 128 or 256 only.
- KEEP_WIDTH, DATA_WIDTH/8, input byte-enable width.
- FIFO_DEPTH, 4, buffer depth in beats; power of two, at least 2.
- user_clk  in  1  clock.
- user_reset_n  in  1  reset: one clock; reset is asynchronous and active-low.
- s_axis_cc_tdata/tkeep/tlast/tvalid  in  DATA_WIDTH/KEEP_WIDTH/1/1  TLP stream from LitePCIe.
- s_axis_cc_tuser  in  4  bit0 ECRC request (first beat only), bit3 discontinue.
- s_axis_cc_tready  out  1  not-full.
- s_axis_cc_tdata_a/tlast_a/tvalid_a  out  DATA_WIDTH/1/1  to the hard block.
- s_axis_cc_tkeep_a  out  DATA_WIDTH/32  dword keep.
- s_axis_cc_tuser_a  out  33  bit0 discontinue, [32:1] parity.
- s_axis_cc_tready_a  in  1  hard-block ready.
- cpl_count  out  16  completions forwarded; wraps modulo 2^16.

## Operation
- Input beat stored as {tuser, dword keep, tlast, tdata}. Dword keep bit i is the OR of tkeep[4i+3:4i].
- Output first-beat flag is set after reset and after any beat with tlast transferred. It clears after any other transfer.
- First-beat descriptor fields, with the input field in brackets:
  - [6:0] lower address [70:64]; [7] 0; [9:8] AT = 0; [15:10] 0.
  - [28:16] byte count, as {1'b0, [43:32]}.
  - [29] locked-read completion, set when [29:24] == 6'b001011; [31:30] 0.
  - [42:32] dword count, 11 bits. Input length [9:0] == 0 encodes 11'd1024; otherwise {1'b0, length}.
  - [45:43] status [47:45]; [46] poison [14]; [47] 0; [63:48] requester ID [95:80].
  - [71:64] tag [79:72]; [87:72] completer ID [63:48]; [88] completer-ID enable = 0.
  - [91:89] TC [22:20]; [94:92] attr, as {1'b0, [13:12]}; [95] force ECRC, as [15] | tuser[0].
  - Bits above 95 pass through unchanged.
- Non-first beats pass through unchanged.
- Discontinue is sticky. Once a transferred output beat carries tuser[3], every later beat of that packet drives tuser_a[0]=1, through tlast. The sticky state clears after tlast.
- cpl_count increments on each output transfer with tlast.

## Timing
- FIFO is first-word-fall-through. A beat accepted in cycle N is presented on the output at cycle N+1 at the earliest.
- Throughput is one beat per cycle when tready_a stays high.
- tready = count < FIFO_DEPTH. A simultaneous push and pop when full is not accepted, because tready is low.
- When empty, tvalid_a = 0. Output payload holds stable while tvalid_a=1 and tready_a=0.
- Count, pointers, first flag, sticky flag and cpl_count update on the user_clk edge. Pointers wrap modulo FIFO_DEPTH.
- Reset, including assertion mid-packet, takes effect asynchronously and discards FIFO contents. All registers and outputs go to 0, except s_axis_cc_tready and the first flag, which go to 1.
- After reset the next output beat is treated as a first beat.

## Configuration
- S_AXIS_CC_PARITY_EN defined: tuser_a[k+1] is the odd parity of output byte k, for every byte the datapath has. Bits above DATA_WIDTH/8 are 0.
- Parity is computed on the rewritten descriptor, not on the raw input.
- Macro undefined: tuser_a[32:1] = 0 and no parity logic is built.

## Structure
- Package s_axis_cc_pkg holds:
  - the input header field offsets;
  - descriptor field offsets;
  - LOCKED_CPL_FMT_TYPE = 6'b001011;
  - a function that maps the length field to the dword count.
- Sub-module cc_sync_fifo is the parametrised FWFT FIFO, with width and depth as parameters and an asynchronous active-low reset.
- Header rewrite, sticky discontinue, parity and the counter live in the top.

## Test plan
- Single-beat CplD: 128-bit, length=1, byte count=4, lower address=0x10, tag=0x2A, requester ID=0x0100, completer ID=0x0200, status=0. Required response:
  - descriptor [6:0]=0x10, [28:16]=4, [42:32]=1, [71:64]=0x2A, [63:48]=0x0100, [87:72]=0x0200;
  - data [127:96] unchanged; tkeep_a=4'b1111; cpl_count=1.
- Length field 0: [42:32]=11'd1024.
- Type [29:24]=6'b001011: bit29=1.
- 256-bit, 3-beat packet with tready_a toggled 1,0,1,0,…:
  - beats arrive in order, with beat 0 rewritten and beats 1–2 unchanged;
  - payload is stable while stalled;
  - tready deasserts after FIFO_DEPTH beats are buffered.
- Discontinue asserted on beat 2 of 4: tuser_a[0]=0,1,1,1. The next packet starts at 0.
- user_reset_n pulsed mid-packet:
  - tvalid_a=0 immediately and cpl_count=0;
  - the next packet's first beat is rewritten.
- With S_AXIS_CC_PARITY_EN: output byte 0x00 gives parity 1, 0x01 gives 0. Without the macro, tuser_a[32:1]=0.
